// File: rtl/vga_box_renderer.sv
// Bouncing-square renderer fed by hvsync_generator; registers colour and syncs together.
// Optional screen border enabled by defining VGA_BOX_BORDER_EN.
module vga_box_renderer #(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter int          BOX_SIZE  = 32,
  parameter int          STEP      = 2,
  parameter logic [2:0]  BOX_COLOR = 3'b100,
  parameter logic [2:0]  BG_COLOR  = 3'b001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vga_h_sync,
  input  logic       vga_v_sync,
  input  logic       inDisplayArea,
  input  logic [9:0] CounterX,
  input  logic [9:0] CounterY,
  input  logic       freeze,
  output logic [2:0] pixel_out,
  output logic       h_sync_out,
  output logic       v_sync_out,
  output logic       frame_tick
);

  typedef enum logic [1:0] {DR, DL, UR, UL} dir_e;

  localparam logic [10:0] MAX_X  = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] MAX_Y  = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [10:0] SIZE11 = 11'(BOX_SIZE);

  dir_e       state_q, state_d;
  logic [9:0] box_x_q, box_x_d;
  logic [9:0] box_y_q, box_y_d;
  logic       vs_q;
  logic       hs_q;
  logic       frame_tick_q, frame_tick_d;
  logic [2:0] pixel_q, pixel_d;

  logic        tick;
  logic        x_right, y_down, nx_right, ny_down;
  logic [10:0] bx, by, cx, cy;
  logic        in_box, border;

  always_comb begin
    state_d  = state_q;
    box_x_d  = box_x_q;
    box_y_d  = box_y_q;
    bx       = {1'b0, box_x_q};
    by       = {1'b0, box_y_q};
    tick     = vs_q & ~vga_v_sync;
    frame_tick_d = tick;
    x_right  = (state_q == DR) || (state_q == UR);
    y_down   = (state_q == DR) || (state_q == DL);
    nx_right = x_right;
    ny_down  = y_down;

    // Axes bounce independently; the state is rebuilt from both new directions.
    if (tick && !freeze) begin
      if (x_right) begin
        if (bx + STEP11 >= MAX_X) begin
          box_x_d  = 10'(MAX_X);
          nx_right = 1'b0;
        end else begin
          box_x_d  = 10'(bx + STEP11);
        end
      end else begin
        if (bx <= STEP11) begin
          box_x_d  = '0;
          nx_right = 1'b1;
        end else begin
          box_x_d  = 10'(bx - STEP11);
        end
      end

      if (y_down) begin
        if (by + STEP11 >= MAX_Y) begin
          box_y_d = 10'(MAX_Y);
          ny_down = 1'b0;
        end else begin
          box_y_d = 10'(by + STEP11);
        end
      end else begin
        if (by <= STEP11) begin
          box_y_d = '0;
          ny_down = 1'b1;
        end else begin
          box_y_d = 10'(by - STEP11);
        end
      end

      state_d = ny_down ? (nx_right ? DR : DL) : (nx_right ? UR : UL);
    end
  end

  always_comb begin
    cx     = {1'b0, CounterX};
    cy     = {1'b0, CounterY};
    in_box = (cx >= {1'b0, box_x_q}) && (cx < {1'b0, box_x_q} + SIZE11) &&
             (cy >= {1'b0, box_y_q}) && (cy < {1'b0, box_y_q} + SIZE11);
`ifdef VGA_BOX_BORDER_EN
    border = (CounterX == 10'd0) || (CounterX == 10'(H_ACTIVE - 1)) ||
             (CounterY == 10'd0) || (CounterY == 10'(V_ACTIVE - 1));
`else
    border = 1'b0;
`endif
    pixel_d = BG_COLOR;
    if (!inDisplayArea) pixel_d = 3'b000;
    else if (border)    pixel_d = 3'b111;
    else if (in_box)    pixel_d = BOX_COLOR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DR;
      box_x_q      <= '0;
      box_y_q      <= '0;
      vs_q         <= 1'b1;
      hs_q         <= 1'b1;
      frame_tick_q <= 1'b0;
      pixel_q      <= '0;
    end else begin
      state_q      <= state_d;
      box_x_q      <= box_x_d;
      box_y_q      <= box_y_d;
      vs_q         <= vga_v_sync;
      hs_q         <= vga_h_sync;
      frame_tick_q <= frame_tick_d;
      pixel_q      <= pixel_d;
    end
  end

  // vs_q doubles as the edge-detect history and the delayed vertical sync.
  assign pixel_out  = pixel_q;
  assign h_sync_out = hs_q;
  assign v_sync_out = vs_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Directed bench for vga_box_renderer: default 640x480 instance plus a 480x480 corner instance.
module tb_vga_box_renderer;

`ifdef VGA_BOX_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vga_h_sync = 1'b1;
  logic       vga_v_sync = 1'b1;
  logic       inDisplayArea = 1'b0;
  logic [9:0] CounterX = '0;
  logic [9:0] CounterY = '0;
  logic       freeze = 1'b0;

  logic [2:0] pixel_out, pixel_out2;
  logic       h_sync_out, v_sync_out, frame_tick;
  logic       h_sync_out2, v_sync_out2, frame_tick2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_box_renderer dut (
    .clk(clk), .rst_n(rst_n), .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
    .inDisplayArea(inDisplayArea), .CounterX(CounterX), .CounterY(CounterY),
    .freeze(freeze), .pixel_out(pixel_out), .h_sync_out(h_sync_out),
    .v_sync_out(v_sync_out), .frame_tick(frame_tick)
  );

  vga_box_renderer #(.H_ACTIVE(480), .V_ACTIVE(480)) dut_sq (
    .clk(clk), .rst_n(rst_n), .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
    .inDisplayArea(inDisplayArea), .CounterX(CounterX), .CounterY(CounterY),
    .freeze(freeze), .pixel_out(pixel_out2), .h_sync_out(h_sync_out2),
    .v_sync_out(v_sync_out2), .frame_tick(frame_tick2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic pix(input int x, input int y, output logic [2:0] p1, output logic [2:0] p2);
    CounterX = 10'(x);
    CounterY = 10'(y);
    inDisplayArea = 1'b1;
    @(negedge clk);
    p1 = pixel_out;
    p2 = pixel_out2;
  endtask

  task automatic chk_pix(input string tag, input int x, input int y, input logic [2:0] exp);
    logic [2:0] p1, p2;
    pix(x, y, p1, p2);
    check_eq(tag, 32'(p1), 32'(exp));
  endtask

  task automatic chk_pix2(input string tag, input int x, input int y, input logic [2:0] exp);
    logic [2:0] p1, p2;
    pix(x, y, p1, p2);
    check_eq(tag, 32'(p2), 32'(exp));
  endtask

  task automatic tick(output logic t0, output logic t1);
    vga_v_sync = 1'b0;
    @(negedge clk);
    t0 = frame_tick;
    vga_v_sync = 1'b1;
    @(negedge clk);
    t1 = frame_tick;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic t0, t1;
    logic [2:0] p1, p2;
    int n;

    @(negedge clk);
    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      vga_h_sync    = 1'($urandom);
      vga_v_sync    = 1'($urandom);
      inDisplayArea = 1'($urandom);
      CounterX      = 10'($urandom_range(0, 639));
      CounterY      = 10'($urandom_range(0, 479));
      freeze        = 1'($urandom);
      @(negedge clk);
      check_eq("rst_pixel", 32'(pixel_out), 32'h0);
      check_eq("rst_hsync", 32'(h_sync_out), 32'h1);
      check_eq("rst_vsync", 32'(v_sync_out), 32'h1);
      check_eq("rst_tick",  32'(frame_tick), 32'h0);
    end
    vga_h_sync = 1'b1;
    vga_v_sync = 1'b1;
    freeze     = 1'b0;
    inDisplayArea = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // One-cycle latency after release, box at (0,0)
    vga_h_sync = 1'b0;
    @(negedge clk);
    check_eq("blank_pixel", 32'(pixel_out), 32'h0);
    check_eq("hsync_delay", 32'(h_sync_out), 32'h0);
    vga_h_sync = 1'b1;
    chk_pix("p0_5_5", 5, 5, 3'b100);
    chk_pix("p0_40_5", 40, 5, 3'b001);
    chk_pix("p0_0_0", 0, 0, BORDER ? 3'b111 : 3'b100);
    chk_pix("p0_1_1", 1, 1, 3'b100);
    chk_pix("p0_0_100", 0, 100, BORDER ? 3'b111 : 3'b001);
    chk_pix("p0_639_479", 639, 479, BORDER ? 3'b111 : 3'b001);
    check_eq("hsync_back", 32'(h_sync_out), 32'h1);

    // First frame tick -> (2,2)
    tick(t0, t1);
    check_eq("tick1_hi", 32'(t0), 32'h1);
    check_eq("tick1_lo", 32'(t1), 32'h0);
    chk_pix("t1_2_2", 2, 2, 3'b100);
    chk_pix("t1_1_2", 1, 2, 3'b001);
    chk_pix("t1_34_2", 34, 2, 3'b001);
    chk_pix("t1_33_2", 33, 2, 3'b100);
    chk_pix("t1_2_33", 2, 33, 3'b100);
    chk_pix("t1_2_34", 2, 34, 3'b001);

    // Long vsync low: exactly one tick -> (4,4)
    n = 0;
    vga_v_sync = 1'b0;
    repeat (10) begin
      @(negedge clk);
      n += int'(frame_tick);
    end
    vga_v_sync = 1'b1;
    @(negedge clk);
    n += int'(frame_tick);
    check_eq("long_low_ticks", 32'(n), 32'd1);
    chk_pix("t2_4_4", 4, 4, 3'b100);
    chk_pix("t2_3_4", 3, 4, 3'b001);

    // Ticks up to 224: y bottoms out at 448, x at 448; 480x480 instance hits the corner
    for (int i = 3; i <= 224; i++) tick(t0, t1);
    chk_pix("t224_448_448", 448, 448, 3'b100);
    chk_pix("t224_447_448", 447, 448, 3'b001);
    chk_pix("t224_448_447", 448, 447, 3'b001);
    chk_pix("t224_479_478", 479, 478, 3'b100);
    chk_pix2("sq224_448_448", 448, 448, 3'b100);
    chk_pix2("sq224_447_447", 447, 447, 3'b001);

    tick(t0, t1);
    chk_pix("t225_450_446", 450, 446, 3'b100);
    chk_pix("t225_449_446", 449, 446, 3'b001);
    chk_pix("t225_450_445", 450, 445, 3'b001);
    chk_pix("t225_481_477", 481, 477, 3'b100);
    chk_pix("t225_482_477", 482, 477, 3'b001);
    chk_pix2("sq225_446_446", 446, 446, 3'b100);
    chk_pix2("sq225_445_446", 445, 446, 3'b001);
    chk_pix2("sq225_446_445", 446, 445, 3'b001);
    chk_pix2("sq225_477_477", 477, 477, 3'b100);
    chk_pix2("sq225_478_477", 478, 477, 3'b001);

    // x reaches right edge at tick 304
    for (int i = 226; i <= 304; i++) tick(t0, t1);
    chk_pix("t304_608_288", 608, 288, 3'b100);
    chk_pix("t304_607_288", 607, 288, 3'b001);
    chk_pix("t304_608_287", 608, 287, 3'b001);
    chk_pix("t304_638_319", 638, 319, 3'b100);
    chk_pix("t304_608_320", 608, 320, 3'b001);

    tick(t0, t1);
    chk_pix("t305_606_286", 606, 286, 3'b100);
    chk_pix("t305_605_286", 605, 286, 3'b001);
    chk_pix("t305_638_286", 638, 286, 3'b001);

    // Freeze: three pulses, no motion
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(t0, t1);
      check_eq("frz_tick_hi", 32'(t0), 32'h1);
      check_eq("frz_tick_lo", 32'(t1), 32'h0);
    end
    freeze = 1'b0;
    chk_pix("frz_606_286", 606, 286, 3'b100);
    chk_pix("frz_605_286", 605, 286, 3'b001);
    chk_pix("frz_606_285", 606, 285, 3'b001);

    // Reset asserted mid-line
    CounterX = 10'd300;
    CounterY = 10'd200;
    inDisplayArea = 1'b1;
    vga_h_sync = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_pixel", 32'(pixel_out), 32'h0);
    check_eq("mid_rst_hsync", 32'(h_sync_out), 32'h1);
    @(negedge clk);
    vga_h_sync = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      n += int'(frame_tick);
    end
    check_eq("no_spurious_tick", 32'(n), 32'd0);
    chk_pix("rst_1_1", 1, 1, 3'b100);
    chk_pix("rst_31_31", 31, 31, 3'b100);
    chk_pix("rst_32_1", 32, 1, 3'b001);
    chk_pix("rst_1_32", 1, 32, 3'b001);

    tick(t0, t1);
    check_eq("rtick_hi", 32'(t0), 32'h1);
    chk_pix("rtick_2_2", 2, 2, 3'b100);
    chk_pix("rtick_1_2", 1, 2, 3'b001);
    chk_pix("rtick_2_1", 2, 1, 3'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
